pipeline_control: RTL

Pipelined successor to the single-cycle control decoder. Decodes the ID-stage instruction, carries control through ID/EX, EX/MEM and MEM/WB registers, and resolves data and control hazards by raising stall, bubble, flush and forwarding selects for the 5-stage datapath. Register-address width and byte-enable width are parameters. Operand forwarding is a compile-time option.

---
 rtl/pipeline_control_if.sv | 42 ++++
 rtl/pipeline_control.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_control_if.sv
// ID-stage instruction fields in, hazard/redirect strobes and per-stage pipeline controls out.
interface pipeline_control_if #(
    parameter int REG_ADDR_W = 5,
    parameter int MEM_WE_W   = 4
);
    logic                  id_valid;
    logic [5:0]            id_opcode;
    logic [5:0]            id_funct;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_equal;

    logic                  stall;
    logic                  flush;
    logic                  jump;
    logic                  jump_sel;
    logic [3:0]            ex_alu_op;
    logic                  ex_alu_a_sel;
    logic                  ex_alu_b_sel;
    logic [1:0]            ex_fwd_a_sel;
    logic [1:0]            ex_fwd_b_sel;
    logic                  ex_illegal;
    logic [MEM_WE_W-1:0]   mem_we;
    logic                  wb_reg_d_we;
    logic [REG_ADDR_W-1:0] wb_reg_d_addr;
    logic                  wb_reg_d_data_sel;

    modport slave (
        input  id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, id_equal,
        output stall, flush, jump, jump_sel,
        output ex_alu_op, ex_alu_a_sel, ex_alu_b_sel, ex_fwd_a_sel, ex_fwd_b_sel, ex_illegal,
        output mem_we, wb_reg_d_we, wb_reg_d_addr, wb_reg_d_data_sel
    );

    modport master (
        output id_valid, id_opcode, id_funct, id_rs, id_rt, id_rd, id_equal,
        input  stall, flush, jump, jump_sel,
        input  ex_alu_op, ex_alu_a_sel, ex_alu_b_sel, ex_fwd_a_sel, ex_fwd_b_sel, ex_illegal,
        input  mem_we, wb_reg_d_we, wb_reg_d_addr, wb_reg_d_data_sel
    );
endinterface

// File: rtl/pipeline_control.sv
// 5-stage pipeline control: ID decode, ID/EX-EX/MEM-MEM/WB control registers, hazard and redirect logic.
// Define PIPELINE_FORWARD_EN to enable operand forwarding (otherwise writers stall readers until WB).
module pipeline_control #(
    parameter int REG_ADDR_W = 5,
    parameter int MEM_WE_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pipeline_control_if.slave bus
);
    localparam logic [5:0] OPCODE_R    = 6'h00;
    localparam logic [5:0] OPCODE_J    = 6'h02;
    localparam logic [5:0] OPCODE_BEQ  = 6'h04;
    localparam logic [5:0] OPCODE_BNE  = 6'h05;
    localparam logic [5:0] OPCODE_ADDI = 6'h08;
    localparam logic [5:0] OPCODE_LW   = 6'h23;
    localparam logic [5:0] OPCODE_SW   = 6'h2B;

    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;
    localparam logic [5:0] FUNCT_SRA = 6'h03;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [3:0] ALU_SLL = 4'd0;
    localparam logic [3:0] ALU_SRL = 4'd1;
    localparam logic [3:0] ALU_SRA = 4'd2;
    localparam logic [3:0] ALU_ADD = 4'd3;
    localparam logic [3:0] ALU_SUB = 4'd4;
    localparam logic [3:0] ALU_AND = 4'd5;
    localparam logic [3:0] ALU_OR  = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;

    localparam logic ALU_A_SEL_SHAMT = 1'b1;
    localparam logic ALU_B_SEL_IMM   = 1'b1;
    localparam logic DATA_SEL_MEM    = 1'b1;

    // ID decode results
    logic [1:0]            used;
    logic                  dec_we;
    logic [REG_ADDR_W-1:0] dec_dest;
    logic [3:0]            dec_alu_op;
    logic                  dec_a_sel;
    logic                  dec_b_sel;
    logic [MEM_WE_W-1:0]   dec_mem_we;
    logic                  dec_data_sel;
    logic                  dec_illegal;
    logic                  is_beq;
    logic                  is_bne;
    logic                  is_j;

    // ID/EX
    logic                  ex_we_reg, ex_we_next;
    logic [REG_ADDR_W-1:0] ex_dest_reg, ex_dest_next;
    logic [3:0]            ex_alu_op_reg, ex_alu_op_next;
    logic                  ex_a_sel_reg, ex_a_sel_next;
    logic                  ex_b_sel_reg, ex_b_sel_next;
    logic [1:0]            ex_fwd_a_reg, ex_fwd_b_reg;
    logic                  ex_illegal_reg, ex_illegal_next;
    logic [MEM_WE_W-1:0]   ex_mem_we_reg, ex_mem_we_next;
    logic                  ex_data_sel_reg, ex_data_sel_next;

    // EX/MEM and MEM/WB
    logic [MEM_WE_W-1:0]   mem_we_reg;
    logic                  mem_reg_we_reg;
    logic [REG_ADDR_W-1:0] mem_dest_reg;
    logic                  mem_data_sel_reg;
    logic                  wb_we_reg;
    logic [REG_ADDR_W-1:0] wb_addr_reg;
    logic                  wb_data_sel_reg;

    logic [REG_ADDR_W-1:0] src [2];
    logic [1:0]            ex_hit;
    logic [1:0]            mem_hit;
    logic [1:0]            fwd_next [2];
    logic                  stall;
    logic                  taken;

    always_comb begin
        used         = 2'b00;
        dec_we       = 1'b0;
        dec_dest     = '0;
        dec_alu_op   = ALU_SLL;
        dec_a_sel    = 1'b0;
        dec_b_sel    = 1'b0;
        dec_mem_we   = '0;
        dec_data_sel = 1'b0;
        dec_illegal  = 1'b0;
        is_beq       = 1'b0;
        is_bne       = 1'b0;
        is_j         = 1'b0;
        if (bus.id_valid) begin
            unique case (bus.id_opcode)
                OPCODE_R: begin
                    dec_we   = 1'b1;
                    dec_dest = bus.id_rd;
                    used     = 2'b11;
                    unique case (bus.id_funct)
                        FUNCT_ADD: dec_alu_op = ALU_ADD;
                        FUNCT_SUB: dec_alu_op = ALU_SUB;
                        FUNCT_AND: dec_alu_op = ALU_AND;
                        FUNCT_OR:  dec_alu_op = ALU_OR;
                        FUNCT_SLT: dec_alu_op = ALU_SLT;
                        FUNCT_SLL, FUNCT_SRL, FUNCT_SRA: begin
                            // Shifts take shamt on A; rs is not a source.
                            used      = 2'b10;
                            dec_a_sel = ALU_A_SEL_SHAMT;
                            dec_alu_op = (bus.id_funct == FUNCT_SLL) ? ALU_SLL :
                                         (bus.id_funct == FUNCT_SRL) ? ALU_SRL : ALU_SRA;
                        end
                        default: begin
                            used        = 2'b00;
                            dec_we      = 1'b0;
                            dec_dest    = '0;
                            dec_illegal = 1'b1;
                        end
                    endcase
                end
                OPCODE_ADDI, OPCODE_LW: begin
                    used         = 2'b01;
                    dec_we       = 1'b1;
                    dec_dest     = bus.id_rt;
                    dec_alu_op   = ALU_ADD;
                    dec_b_sel    = ALU_B_SEL_IMM;
                    dec_data_sel = (bus.id_opcode == OPCODE_LW) ? DATA_SEL_MEM : 1'b0;
                end
                OPCODE_SW: begin
                    used       = 2'b11;
                    dec_alu_op = ALU_ADD;
                    dec_b_sel  = ALU_B_SEL_IMM;
                    dec_mem_we = {MEM_WE_W{1'b1}};
                end
                OPCODE_BEQ: begin
                    used   = 2'b11;
                    is_beq = 1'b1;
                end
                OPCODE_BNE: begin
                    used   = 2'b11;
                    is_bne = 1'b1;
                end
                OPCODE_J: is_j = 1'b1;
                default:  dec_illegal = 1'b1;
            endcase
        end
    end

    assign src[0] = bus.id_rs;
    assign src[1] = bus.id_rt;

    // Index 0 tracks rs (operand A), index 1 tracks rt (operand B); $0 never matches.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign ex_hit[gi]  = used[gi] && ex_we_reg && (ex_dest_reg != '0) && (ex_dest_reg == src[gi]);
            assign mem_hit[gi] = used[gi] && mem_reg_we_reg && (mem_dest_reg != '0) && (mem_dest_reg == src[gi]);
`ifdef PIPELINE_FORWARD_EN
            assign fwd_next[gi] = stall      ? 2'd0 :
                                  ex_hit[gi]  ? 2'd1 :
                                  mem_hit[gi] ? 2'd2 : 2'd0;
`else
            assign fwd_next[gi] = 2'd0;
`endif
        end
    endgenerate

`ifdef PIPELINE_FORWARD_EN
    logic load_use;
    logic branch_hazard;
    // Branches compare in ID, so an ALU result still in EX or a load still in MEM is not yet usable.
    assign load_use      = ex_data_sel_reg && (|ex_hit);
    assign branch_hazard = (is_beq || is_bne) && ((|ex_hit) || (mem_data_sel_reg && (|mem_hit)));
    assign stall         = load_use || branch_hazard;
`else
    assign stall = (|ex_hit) || (|mem_hit);
`endif

    assign taken = is_j || (is_beq && bus.id_equal) || (is_bne && !bus.id_equal);

    assign bus.stall    = stall;
    assign bus.jump     = taken && !stall;
    assign bus.flush    = taken && !stall;
    assign bus.jump_sel = is_j;

    always_comb begin
        ex_we_next       = dec_we;
        ex_dest_next     = dec_dest;
        ex_alu_op_next   = dec_alu_op;
        ex_a_sel_next    = dec_a_sel;
        ex_b_sel_next    = dec_b_sel;
        ex_illegal_next  = dec_illegal;
        ex_mem_we_next   = dec_mem_we;
        ex_data_sel_next = dec_data_sel;
        if (stall) begin
            ex_we_next       = 1'b0;
            ex_dest_next     = '0;
            ex_alu_op_next   = ALU_SLL;
            ex_a_sel_next    = 1'b0;
            ex_b_sel_next    = 1'b0;
            ex_illegal_next  = 1'b0;
            ex_mem_we_next   = '0;
            ex_data_sel_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_we_reg        <= 1'b0;
            ex_dest_reg      <= '0;
            ex_alu_op_reg    <= ALU_SLL;
            ex_a_sel_reg     <= 1'b0;
            ex_b_sel_reg     <= 1'b0;
            ex_fwd_a_reg     <= 2'd0;
            ex_fwd_b_reg     <= 2'd0;
            ex_illegal_reg   <= 1'b0;
            ex_mem_we_reg    <= '0;
            ex_data_sel_reg  <= 1'b0;
            mem_we_reg       <= '0;
            mem_reg_we_reg   <= 1'b0;
            mem_dest_reg     <= '0;
            mem_data_sel_reg <= 1'b0;
            wb_we_reg        <= 1'b0;
            wb_addr_reg      <= '0;
            wb_data_sel_reg  <= 1'b0;
        end else begin
            ex_we_reg        <= ex_we_next;
            ex_dest_reg      <= ex_dest_next;
            ex_alu_op_reg    <= ex_alu_op_next;
            ex_a_sel_reg     <= ex_a_sel_next;
            ex_b_sel_reg     <= ex_b_sel_next;
            ex_fwd_a_reg     <= fwd_next[0];
            ex_fwd_b_reg     <= fwd_next[1];
            ex_illegal_reg   <= ex_illegal_next;
            ex_mem_we_reg    <= ex_mem_we_next;
            ex_data_sel_reg  <= ex_data_sel_next;
            mem_we_reg       <= ex_mem_we_reg;
            mem_reg_we_reg   <= ex_we_reg;
            mem_dest_reg     <= ex_dest_reg;
            mem_data_sel_reg <= ex_data_sel_reg;
            wb_we_reg        <= mem_reg_we_reg;
            wb_addr_reg      <= mem_dest_reg;
            wb_data_sel_reg  <= mem_data_sel_reg;
        end
    end

    assign bus.ex_alu_op         = ex_alu_op_reg;
    assign bus.ex_alu_a_sel      = ex_a_sel_reg;
    assign bus.ex_alu_b_sel      = ex_b_sel_reg;
    assign bus.ex_fwd_a_sel      = ex_fwd_a_reg;
    assign bus.ex_fwd_b_sel      = ex_fwd_b_reg;
    assign bus.ex_illegal        = ex_illegal_reg;
    assign bus.mem_we            = mem_we_reg;
    assign bus.wb_reg_d_we       = wb_we_reg;
    assign bus.wb_reg_d_addr     = wb_addr_reg;
    assign bus.wb_reg_d_data_sel = wb_data_sel_reg;
endmodule
